// File: rtl/csla_pkg.sv
// Shared sizing helpers for the pipelined carry-select adder.
package csla_pkg;

  function automatic int csla_width(input int rca_width, input int blk_width, input int blk_num);
    return rca_width + blk_width * blk_num;
  endfunction

  function automatic int csla_blk_per_stage(input int blk_num, input int nstage);
    return (nstage > 0) ? (blk_num / nstage) : blk_num;
  endfunction

endpackage

// File: rtl/csla_pipe_stage.sv
// One pipeline stage worth of carry-select blocks plus the carry select chain.
module csla_pipe_stage #(
  parameter int BLK_WIDTH = 6,
  parameter int NBLK      = 2
) (
  input  logic [NBLK*BLK_WIDTH-1:0] i_a,
  input  logic [NBLK*BLK_WIDTH-1:0] i_b,
  input  logic                      i_cin,
  output logic [NBLK*BLK_WIDTH-1:0] o_sum,
  output logic                      o_cout
);

  logic [BLK_WIDTH-1:0] sum0 [NBLK];
  logic [BLK_WIDTH-1:0] sum1 [NBLK];
  logic [NBLK-1:0]      cout0;
  logic [NBLK-1:0]      cout1;
  logic [NBLK:0]        carry;

  for (genvar j = 0; j < NBLK; j++) begin : g_unit
    csla_unit #(.W(BLK_WIDTH)) u_unit (
      .i_a     (i_a[j*BLK_WIDTH +: BLK_WIDTH]),
      .i_b     (i_b[j*BLK_WIDTH +: BLK_WIDTH]),
      .o_sum0  (sum0[j]),
      .o_sum1  (sum1[j]),
      .o_cout0 (cout0[j]),
      .o_cout1 (cout1[j])
    );
  end

  always_comb begin
    carry    = {(NBLK+1){1'b0}};
    carry[0] = i_cin;
    o_sum    = {(NBLK*BLK_WIDTH){1'b0}};
    for (int j = 0; j < NBLK; j++) begin
      o_sum[j*BLK_WIDTH +: BLK_WIDTH] = carry[j] ? sum1[j] : sum0[j];
      carry[j+1]                      = carry[j] ? cout1[j] : cout0[j];
    end
    o_cout = carry[NBLK];
  end

endmodule

// File: rtl/csla_unit.sv
// Dual-sum unit: precomputes the block sum for carry-in 0 and carry-in 1.
module csla_unit #(
  parameter int W = 6
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum0,
  output logic [W-1:0] o_sum1,
  output logic         o_cout0,
  output logic         o_cout1
);

  always_comb begin
    {o_cout0, o_sum0} = {1'b0, i_a} + {1'b0, i_b};
    {o_cout1, o_sum1} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/csla_pipe.sv
// Pipelined carry-select adder with valid/ready flow control.
// Define CSLA_SUB_EN to add the i_sub port (A - B via ~B and carry-in 1).
module csla_pipe
  import csla_pkg::*;
#(
  parameter int RCA_WIDTH = 5,
  parameter int BLK_WIDTH = 6,
  parameter int BLK_NUM   = 4,
  parameter int NSTAGE    = 2
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                i_valid,
  output logic                                                o_ready,
  input  logic [csla_width(RCA_WIDTH, BLK_WIDTH, BLK_NUM)-1:0] i_X_0,
  input  logic [csla_width(RCA_WIDTH, BLK_WIDTH, BLK_NUM)-1:0] i_X_1,
`ifdef CSLA_SUB_EN
  input  logic                                                i_sub,
`endif
  output logic                                                o_valid,
  input  logic                                                i_ready,
  output logic [csla_width(RCA_WIDTH, BLK_WIDTH, BLK_NUM):0]   o_S
);

  localparam int WIDTH = csla_width(RCA_WIDTH, BLK_WIDTH, BLK_NUM);
  localparam int NB    = csla_blk_per_stage(BLK_NUM, NSTAGE);
  localparam int SW    = NB * BLK_WIDTH;
  localparam int LAST  = NSTAGE - 1;

  if (NSTAGE < 1 || NSTAGE > BLK_NUM || (BLK_NUM % NSTAGE) != 0) begin : g_bad_cfg
    $error("csla_pipe: NSTAGE must be 1..BLK_NUM and divide BLK_NUM");
  end

  logic [WIDTH-1:0]     b_eff;
  logic                 cin;
  logic [RCA_WIDTH:0]   rca;
  logic [WIDTH-1:0]     src_a [NSTAGE];
  logic [WIDTH-1:0]     src_b [NSTAGE];
  logic [WIDTH-1:0]     src_s [NSTAGE];
  logic                 src_c [NSTAGE];
  logic [SW-1:0]        stg_sum [NSTAGE];
  logic [NSTAGE-1:0]    stg_cout;
  logic [NSTAGE-1:0]    ld;
  logic [NSTAGE:0]      v_shift;
  logic [NSTAGE-1:0]    v_in;
  logic [NSTAGE-1:0]    v_d, v_q;
  logic [WIDTH-1:0]     a_d [NSTAGE];
  logic [WIDTH-1:0]     a_q [NSTAGE];
  logic [WIDTH-1:0]     b_d [NSTAGE];
  logic [WIDTH-1:0]     b_q [NSTAGE];
  logic [WIDTH-1:0]     s_d [NSTAGE];
  logic [WIDTH-1:0]     s_q [NSTAGE];
  logic                 c_d [NSTAGE];
  logic                 c_q [NSTAGE];
  logic [WIDTH:0]       o_s_d, o_s_q;

  // Operand conditioning and the low ripple segment, done before stage 0 registers.
  always_comb begin
`ifdef CSLA_SUB_EN
    cin   = i_sub;
    b_eff = i_sub ? ~i_X_1 : i_X_1;
`else
    cin   = 1'b0;
    b_eff = i_X_1;
`endif
    rca = {1'b0, i_X_0[RCA_WIDTH-1:0]} + {1'b0, b_eff[RCA_WIDTH-1:0]} + {{RCA_WIDTH{1'b0}}, cin};
  end

  always_comb begin
    src_a[0] = i_X_0;
    src_b[0] = b_eff;
    src_s[0] = {{(WIDTH-RCA_WIDTH){1'b0}}, rca[RCA_WIDTH-1:0]};
    src_c[0] = rca[RCA_WIDTH];
    for (int k = 1; k < NSTAGE; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    csla_pipe_stage #(.BLK_WIDTH(BLK_WIDTH), .NBLK(NB)) u_stage (
      .i_a    (src_a[k][RCA_WIDTH + k*SW +: SW]),
      .i_b    (src_b[k][RCA_WIDTH + k*SW +: SW]),
      .i_cin  (src_c[k]),
      .o_sum  (stg_sum[k]),
      .o_cout (stg_cout[k])
    );
  end

  // A stage loads when it is empty or its current content moves on.
  always_comb begin
    ld       = {NSTAGE{1'b0}};
    ld[LAST] = !v_q[LAST] | i_ready;
    for (int k = NSTAGE - 2; k >= 0; k--) begin
      ld[k] = !v_q[k] | ld[k+1];
    end
  end

  always_comb begin
    v_shift = {v_q, i_valid};
    v_in    = v_shift[NSTAGE-1:0];
    for (int k = 0; k < NSTAGE; k++) begin
      v_d[k] = ld[k] ? v_in[k] : v_q[k];
      if (ld[k]) begin
        a_d[k] = src_a[k];
        b_d[k] = src_b[k];
        s_d[k] = src_s[k];
        s_d[k][RCA_WIDTH + k*SW +: SW] = stg_sum[k];
        c_d[k] = stg_cout[k];
      end else begin
        a_d[k] = a_q[k];
        b_d[k] = b_q[k];
        s_d[k] = s_q[k];
        c_d[k] = c_q[k];
      end
    end
    // Output word is forced to zero whenever no valid result sits in it.
    if (ld[LAST]) begin
      o_s_d = v_in[LAST] ? {c_d[LAST], s_d[LAST]} : {(WIDTH+1){1'b0}};
    end else begin
      o_s_d = o_s_q;
    end
  end

  // Control state: valids and the output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= {NSTAGE{1'b0}};
      o_s_q <= {(WIDTH+1){1'b0}};
    end else begin
      v_q   <= v_d;
      o_s_q <= o_s_d;
    end
  end

  // Datapath state: meaningless while the matching valid is low.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTAGE; k++) begin
      a_q[k] <= a_d[k];
      b_q[k] <= b_d[k];
      s_q[k] <= s_d[k];
      c_q[k] <= c_d[k];
    end
  end

  assign o_ready = ld[0];
  assign o_valid = v_q[LAST];
  assign o_S     = o_s_q;

endmodule

// File: tb/tb_csla_pipe.sv
// Self-checking bench for csla_pipe: directed cases on NSTAGE=2 plus random traffic on NSTAGE=1,2,4.
module tb_csla_pipe;

`ifdef CSLA_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  localparam int M      = 1;
  localparam int NS_M   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b1;
  logic        i_sub = 1'b0;
  logic [28:0] i_x0 = 29'd0;
  logic [28:0] i_x1 = 29'd0;
  logic        o_ready [3];
  logic        o_valid [3];
  logic [29:0] o_s [3];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    csla_pipe #(.NSTAGE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .o_ready (o_ready[g]),
      .i_X_0   (i_x0),
      .i_X_1   (i_x1),
`ifdef CSLA_SUB_EN
      .i_sub   (i_sub),
`endif
      .o_valid (o_valid[g]),
      .i_ready (i_ready),
      .o_S     (o_s[g])
    );
  end

  // Reference: plain integer arithmetic; subtraction is A - B + 2^29 folded to 30 bits.
  function automatic logic [29:0] ref_sum(input logic [28:0] a, input logic [28:0] b, input logic sub);
    longint r;
    if (sub && SUB_EN) r = longint'(a) - longint'(b) + (longint'(1) << 29);
    else               r = longint'(a) + longint'(b);
    return r[29:0];
  endfunction

  task automatic send_one(input logic [28:0] a, input logic [28:0] b, input logic sub,
                          output logic [29:0] res, output int lat);
    i_x0 = a; i_x1 = b; i_sub = sub; i_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = -1;
    res = 30'd0;
    for (int c = 1; c <= 20; c++) begin
      if (o_valid[M]) begin
        lat = c;
        res = o_s[M];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (o_valid[M] !== 1'b0) $display("FAIL reset_valid: got %0b want 0", o_valid[M]); else n_pass++;
    n_total++; if (o_s[M] !== 30'd0) $display("FAIL reset_sum: got %h want 0", o_s[M]); else n_pass++;
    n_total++; if (o_ready[M] !== 1'b1) $display("FAIL reset_ready: got %0b want 1", o_ready[M]); else n_pass++;
  endtask

  task automatic test_carry;
    logic [29:0] res;
    int lat;
    send_one(29'h1FFFFFFF, 29'h1FFFFFFF, 1'b0, res, lat);
    n_total++; if (res !== 30'h3FFFFFFE) $display("FAIL max_sum: got %h want 3ffffffe", res); else n_pass++;
    n_total++; if (lat !== NS_M) $display("FAIL latency: got %0d want %0d", lat, NS_M); else n_pass++;
    n_total++; if (o_valid[M] !== 1'b0) $display("FAIL no_dup: got o_valid %0b want 0", o_valid[M]); else n_pass++;
    send_one(29'h1FFFFFFF, 29'h00000001, 1'b0, res, lat);
    n_total++; if (res !== 30'h20000000) $display("FAIL full_ripple: got %h want 20000000", res); else n_pass++;
    send_one(29'h0000001F, 29'h00000001, 1'b0, res, lat);
    n_total++; if (res !== 30'h00000020) $display("FAIL rca_carry: got %h want 00000020", res); else n_pass++;
    n_total++; if (lat !== NS_M) $display("FAIL latency2: got %0d want %0d", lat, NS_M); else n_pass++;
  endtask

  task automatic test_sub;
    logic [29:0] res;
    int lat;
`ifdef CSLA_SUB_EN
    send_one(29'd5, 29'd7, 1'b1, res, lat);
    n_total++; if (res !== 30'h1FFFFFFE) $display("FAIL sub_borrow: got %h want 1ffffffe", res); else n_pass++;
    send_one(29'd7, 29'd5, 1'b1, res, lat);
    n_total++; if (res !== 30'h20000002) $display("FAIL sub_noborrow: got %h want 20000002", res); else n_pass++;
`else
    send_one(29'd0, 29'd0, 1'b0, res, lat);
    n_total++; if (res !== 30'd0) $display("FAIL zero_sum: got %h want 0", res); else n_pass++;
    send_one(29'h15555555, 29'h0AAAAAAA, 1'b0, res, lat);
    n_total++; if (res !== 30'h1FFFFFFF) $display("FAIL alt_bits: got %h want 1fffffff", res); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back_stall;
    logic [28:0] qa[$];
    logic [28:0] qb[$];
    logic [29:0] expv[$];
    logic [29:0] got[$];
    int          got_cyc[$];
    bit          first = 1'b0;
    int          cnt = 0;
    qa = '{29'd1, 29'd3, 29'd5};
    qb = '{29'd2, 29'd4, 29'd6};
    for (int i = 0; i < 3; i++) expv.push_back(ref_sum(qa[i], qb[i], 1'b0));
    i_sub = 1'b0;
    for (int cy = 0; cy < 40 && got.size() < 3; cy++) begin
      if (o_valid[M]) first = 1'b1;
      i_ready = first && (cnt >= 5);
      i_valid = (qa.size() > 0);
      if (i_valid) begin i_x0 = qa[0]; i_x1 = qb[0]; end
      #1;
      if (o_valid[M] && !i_ready) begin
        n_total++; if (o_s[M] !== expv[0]) $display("FAIL stall_hold: got %h want %h", o_s[M], expv[0]); else n_pass++;
        if (cnt == 4) begin
          n_total++; if (o_ready[M] !== 1'b0) $display("FAIL full_ready: got %0b want 0", o_ready[M]); else n_pass++;
        end
      end
      if (o_valid[M] && i_ready) begin got.push_back(o_s[M]); got_cyc.push_back(cy); end
      if (i_valid && o_ready[M]) begin void'(qa.pop_front()); void'(qb.pop_front()); end
      if (first) cnt++;
      @(posedge clk); #1;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    n_total++; if (got.size() != 3) $display("FAIL stall_count: got %0d results want 3", got.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < 3; i++) begin
      n_total++; if (got[i] !== expv[i]) $display("FAIL stall_order[%0d]: got %h want %h", i, got[i], expv[i]); else n_pass++;
      if (i > 0) begin
        n_total++; if (got_cyc[i] != got_cyc[i-1] + 1) $display("FAIL stall_gap[%0d]: got cycle %0d want %0d", i, got_cyc[i], got_cyc[i-1] + 1); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_inflight;
    logic [29:0] res;
    int lat;
    int stale = 0;
    i_ready = 1'b0; i_sub = 1'b0;
    i_valid = 1'b1; i_x0 = 29'd100; i_x1 = 29'd200;
    @(posedge clk); #1;
    i_x0 = 29'd300; i_x1 = 29'd400;
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_total++; if (o_valid[M] !== 1'b0) $display("FAIL rst_flight_valid: got %0b want 0", o_valid[M]); else n_pass++;
    n_total++; if (o_s[M] !== 30'd0) $display("FAIL rst_flight_sum: got %h want 0", o_s[M]); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (o_valid[M]) stale++;
      @(posedge clk); #1;
    end
    n_total++; if (stale != 0) $display("FAIL rst_stale: got %0d stale results want 0", stale); else n_pass++;
    send_one(29'd10, 29'd20, 1'b0, res, lat);
    n_total++; if (res !== 30'd30) $display("FAIL rst_next: got %h want 1e", res); else n_pass++;
    n_total++; if (lat !== NS_M) $display("FAIL rst_next_lat: got %0d want %0d", lat, NS_M); else n_pass++;
  endtask

  task automatic test_random;
    logic [29:0] expq [3][$];
    logic        pv [3];
    logic        pr;
    logic [29:0] ps [3];
    logic [28:0] a, b;
    logic [29:0] e;
    int          sel;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin pv[d] = 1'b0; ps[d] = 30'd0; end
    pr = 1'b1;
    for (int cy = 0; cy < 10030; cy++) begin
      if (cy < 10000) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_ready = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 7);
        a = (sel == 0) ? 29'h1FFFFFFF : 29'($urandom);
        b = (sel == 1) ? 29'h1FFFFFFF : ((sel == 2) ? 29'd1 : 29'($urandom));
        i_x0 = a; i_x1 = b;
        i_sub = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        i_valid = 1'b0; i_ready = 1'b1;
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        if (pv[d] && !pr) begin
          n_total++;
          if (o_valid[d] !== 1'b1 || o_s[d] !== ps[d])
            $display("FAIL rand_hold[%0d]: got v=%0b s=%h want v=1 s=%h", d, o_valid[d], o_s[d], ps[d]);
          else n_pass++;
        end
        if (o_valid[d] && i_ready) begin
          n_total++;
          if (expq[d].size() == 0) $display("FAIL rand_extra[%0d]: got %h want none", d, o_s[d]);
          else begin
            e = expq[d].pop_front();
            if (o_s[d] !== e) $display("FAIL rand_sum[%0d]: got %h want %h", d, o_s[d], e);
            else n_pass++;
          end
        end
        if (i_valid && o_ready[d]) expq[d].push_back(ref_sum(i_x0, i_x1, i_sub));
        pv[d] = o_valid[d];
        ps[d] = o_s[d];
      end
      pr = i_ready;
      @(posedge clk); #1;
    end
    for (int d = 0; d < 3; d++) begin
      n_total++; if (expq[d].size() != 0) $display("FAIL rand_lost[%0d]: got %0d pending want 0", d, expq[d].size()); else n_pass++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_carry();
    test_sub();
    test_back_to_back_stall();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
